// File: rtl/exec_pkg.sv
// Shared encodings for the execute stage: ALU, shifter and mul/div opcodes
// plus the state type of the iterative multiply/divide unit.
package exec_pkg;

  typedef enum logic [2:0] {
    ALU_ADD   = 3'b000,
    ALU_SUB   = 3'b001,
    ALU_AND   = 3'b010,
    ALU_OR    = 3'b011,
    ALU_XOR   = 3'b100,
    ALU_NOR   = 3'b101,
    ALU_SLT   = 3'b110,
    ALU_PASSB = 3'b111
  } aluop_e;

  typedef enum logic [1:0] {
    SH_SLL = 2'b00,
    SH_SRL = 2'b01,
    SH_SRA = 2'b10,
    SH_ROR = 2'b11
  } shiftop_e;

  typedef enum logic [1:0] {
    MD_NONE = 2'b00,
    MD_MUL  = 2'b01,
    MD_DIV  = 2'b10,
    MD_REM  = 2'b11
  } mdop_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    DONE = 2'b10
  } md_state_t;

  // Divide by zero never traps: every quotient bit is filled with this value.
  localparam logic DIV0_QUOT_FILL = 1'b1;

endpackage

// File: rtl/md_unit.sv
// Iterative multiply/divide: shift-add multiply and restoring division over
// magnitudes, one iteration per cycle for W cycles, result held in DONE.
module md_unit
  import exec_pkg::*;
#(
  parameter int W = 32
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         start,
  input  logic [1:0]   op,
  input  logic         unsig,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         hold,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] result
);

  localparam int CW = $clog2(W) + 1;
  localparam logic [CW-1:0] LAST = CW'(W - 1);

  md_state_t      state, state_n;
  logic [CW-1:0]  count;
  mdop_e          op_q;
  logic           neg_q, rem_neg_q, div0_q;
  logic [W-1:0]   a_q, acc, mcand, mplier, quo, rem, dvsr;
  logic           a_neg, b_neg, accept, rem_ge;
  logic [W-1:0]   a_mag, b_mag;
  logic [W:0]     rem_shift;

  assign accept    = (state == IDLE) && start;
  assign busy      = (state == BUSY);
  assign done      = (state == DONE);
  assign a_neg     = !unsig && a[W-1];
  assign b_neg     = !unsig && b[W-1];
  assign a_mag     = a_neg ? -a : a;
  assign b_mag     = b_neg ? -b : b;
  assign rem_shift = {rem, quo[W-1]};
  assign rem_ge    = (rem_shift >= {1'b0, dvsr});

  // NOTE: every variable written here gets a default first, so no latch is inferred.
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (accept) state_n = BUSY;
      BUSY:    if (count == LAST) state_n = DONE;
      DONE:    if (!hold) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      count <= '0;
    end else begin
      state <= state_n;
      if (accept)             count <= '0;
      else if (state == BUSY) count <= count + CW'(1);
    end
  end

  // NOTE: datapath registers are loaded on accept before any use, so they carry no reset.
  always_ff @(posedge clock) begin
    if (accept) begin
      op_q      <= mdop_e'(op);
      a_q       <= a;
      neg_q     <= a_neg ^ b_neg;
      rem_neg_q <= a_neg;
      div0_q    <= (b == '0);
      acc       <= '0;
      mcand     <= a;
      mplier    <= b;
      quo       <= a_mag;
      rem       <= '0;
      dvsr      <= b_mag;
    end else if (state == BUSY) begin
      if (op_q == MD_MUL) begin
        if (mplier[0]) acc <= acc + mcand;
        mcand  <= {mcand[W-2:0], 1'b0};
        mplier <= {1'b0, mplier[W-1:1]};
      end else begin
        quo <= {quo[W-2:0], rem_ge};
        rem <= rem_ge ? (rem_shift[W-1:0] - dvsr) : rem_shift[W-1:0];
      end
    end
  end

  always_comb begin
    result = acc;
    case (op_q)
      MD_DIV:  result = div0_q ? {W{DIV0_QUOT_FILL}} : (neg_q ? -quo : quo);
      MD_REM:  result = div0_q ? a_q : (rem_neg_q ? -rem : rem);
      default: result = acc;
    endcase
  end

endmodule

// File: rtl/execute_md.sv
// Execute stage: combinational ALU and shifter, iterative mul/div, and the
// id_mem_* pipeline register with memory back-pressure and decode stall.
module execute_md
  import exec_pkg::*;
#(
  parameter int W  = 32,
  parameter int SW = $clog2(W),
  parameter int RW = 5
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          id_ex_valid,
  input  logic          id_ex_selalushift,
  input  logic          id_ex_selimregb,
  input  logic [2:0]    id_ex_aluop,
  input  logic          id_ex_unsig,
  input  logic [1:0]    id_ex_shiftop,
  input  logic [SW-1:0] id_ex_shiftamt,
  input  logic [1:0]    id_ex_mdop,
  input  logic [W-1:0]  id_ex_rega,
  input  logic [W-1:0]  id_ex_regb,
  input  logic [W-1:0]  id_ex_imedext,
  input  logic          id_ex_readmem,
  input  logic          id_ex_writemem,
  input  logic          id_ex_selwsource,
  input  logic          id_ex_writereg,
  input  logic          id_ex_writeov,
  input  logic [RW-1:0] id_ex_regdest,
  input  logic          mem_stall,
  output logic          id_if_stall,
  output logic          ex_mem_valid,
  output logic          id_mem_readmem,
  output logic          id_mem_writemem,
  output logic          id_mem_selwsource,
  output logic          id_mem_writereg,
  output logic [W-1:0]  id_mem_regb,
  output logic [W-1:0]  id_mem_wbvalue,
  output logic [RW-1:0] id_mem_regdest
);

  logic [W-1:0]  opb, sum, diff, alu_res, sh_res, md_res, ex_res;
  logic [SW-1:0] rot_amt;
  logic          lt, aluov, md_req, md_busy, md_done, md_idle;

  assign opb  = id_ex_selimregb ? id_ex_imedext : id_ex_regb;
  assign sum  = id_ex_rega + opb;
  assign diff = id_ex_rega - opb;
  assign lt   = id_ex_unsig ? (id_ex_rega < opb) : ($signed(id_ex_rega) < $signed(opb));

  always_comb begin
    alu_res = opb;
    aluov   = 1'b0;
    case (aluop_e'(id_ex_aluop))
      ALU_ADD: begin
        alu_res = sum;
        aluov   = !id_ex_unsig && (id_ex_rega[W-1] == opb[W-1]) && (sum[W-1] != id_ex_rega[W-1]);
      end
      ALU_SUB: begin
        alu_res = diff;
        aluov   = !id_ex_unsig && (id_ex_rega[W-1] != opb[W-1]) && (diff[W-1] != id_ex_rega[W-1]);
      end
      ALU_AND: alu_res = id_ex_rega & opb;
      ALU_OR:  alu_res = id_ex_rega | opb;
      ALU_XOR: alu_res = id_ex_rega ^ opb;
      ALU_NOR: alu_res = ~(id_ex_rega | opb);
      ALU_SLT: alu_res = {{(W-1){1'b0}}, lt};
      default: alu_res = opb;
    endcase
  end

  // Rotate right by n is the OR of a right shift by n and a left shift by -n mod W.
  assign rot_amt = SW'(0) - id_ex_shiftamt;

  always_comb begin
    sh_res = id_ex_regb;
    case (shiftop_e'(id_ex_shiftop))
      SH_SLL:  sh_res = id_ex_regb << id_ex_shiftamt;
      SH_SRL:  sh_res = id_ex_regb >> id_ex_shiftamt;
      SH_SRA:  sh_res = W'($signed(id_ex_regb) >>> id_ex_shiftamt);
      default: sh_res = (id_ex_regb >> id_ex_shiftamt) | (id_ex_regb << rot_amt);
    endcase
  end

  assign ex_res      = id_ex_selalushift ? sh_res : alu_res;
  assign md_req      = id_ex_valid && (mdop_e'(id_ex_mdop) != MD_NONE);
  assign md_idle     = !md_busy && !md_done;
  assign id_if_stall = mem_stall || md_busy || (md_idle && md_req);

  md_unit #(.W(W)) u_md (
    .clock  (clock),
    .reset  (reset),
    .start  (md_req && !mem_stall),
    .op     (id_ex_mdop),
    .unsig  (id_ex_unsig),
    .a      (id_ex_rega),
    .b      (opb),
    .hold   (mem_stall),
    .busy   (md_busy),
    .done   (md_done),
    .result (md_res)
  );

  // NOTE: pipeline state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock) begin
    if (reset) begin
      ex_mem_valid      <= 1'b0;
      id_mem_readmem    <= 1'b0;
      id_mem_writemem   <= 1'b0;
      id_mem_selwsource <= 1'b0;
      id_mem_writereg   <= 1'b0;
      id_mem_regb       <= '0;
      id_mem_wbvalue    <= '0;
      id_mem_regdest    <= '0;
    end else if (!mem_stall) begin
      if (md_done || (md_idle && id_ex_valid && !md_req)) begin
        ex_mem_valid      <= 1'b1;
        id_mem_readmem    <= id_ex_readmem;
        id_mem_writemem   <= id_ex_writemem;
        id_mem_selwsource <= id_ex_selwsource;
        id_mem_regb       <= id_ex_regb;
        id_mem_regdest    <= id_ex_regdest;
        if (md_done) begin
          id_mem_wbvalue  <= md_res;
          id_mem_writereg <= id_ex_writereg;
        end else begin
          id_mem_wbvalue  <= ex_res;
          id_mem_writereg <= (!(aluov && !id_ex_selalushift) || id_ex_writeov) && id_ex_writereg;
        end
      end else begin
        // Bubble while idle without an instruction or while mul/div is in flight.
        ex_mem_valid    <= 1'b0;
        id_mem_readmem  <= 1'b0;
        id_mem_writemem <= 1'b0;
        id_mem_writereg <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_execute_md.sv
// Scoreboard bench for execute_md (W=32): expected results are queued when an
// instruction is driven and popped when the pipeline register shows it.
module tb_execute_md;

  localparam int W = 32;

  logic        clock = 1'b0;
  logic        reset;
  logic        id_ex_valid, id_ex_selalushift, id_ex_selimregb, id_ex_unsig;
  logic [2:0]  id_ex_aluop;
  logic [1:0]  id_ex_shiftop, id_ex_mdop;
  logic [4:0]  id_ex_shiftamt, id_ex_regdest, id_mem_regdest;
  logic [31:0] id_ex_rega, id_ex_regb, id_ex_imedext, id_mem_regb, id_mem_wbvalue;
  logic        id_ex_readmem, id_ex_writemem, id_ex_selwsource, id_ex_writereg, id_ex_writeov;
  logic        mem_stall, id_if_stall, ex_mem_valid;
  logic        id_mem_readmem, id_mem_writemem, id_mem_selwsource, id_mem_writereg;

  execute_md #(.W(W), .SW(5), .RW(5)) dut (
    .clock(clock), .reset(reset), .id_ex_valid(id_ex_valid),
    .id_ex_selalushift(id_ex_selalushift), .id_ex_selimregb(id_ex_selimregb),
    .id_ex_aluop(id_ex_aluop), .id_ex_unsig(id_ex_unsig), .id_ex_shiftop(id_ex_shiftop),
    .id_ex_shiftamt(id_ex_shiftamt), .id_ex_mdop(id_ex_mdop), .id_ex_rega(id_ex_rega),
    .id_ex_regb(id_ex_regb), .id_ex_imedext(id_ex_imedext), .id_ex_readmem(id_ex_readmem),
    .id_ex_writemem(id_ex_writemem), .id_ex_selwsource(id_ex_selwsource),
    .id_ex_writereg(id_ex_writereg), .id_ex_writeov(id_ex_writeov),
    .id_ex_regdest(id_ex_regdest), .mem_stall(mem_stall), .id_if_stall(id_if_stall),
    .ex_mem_valid(ex_mem_valid), .id_mem_readmem(id_mem_readmem),
    .id_mem_writemem(id_mem_writemem), .id_mem_selwsource(id_mem_selwsource),
    .id_mem_writereg(id_mem_writereg), .id_mem_regb(id_mem_regb),
    .id_mem_wbvalue(id_mem_wbvalue), .id_mem_regdest(id_mem_regdest)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic        sel_sh, sel_imm;
    logic [2:0]  aluop;
    logic        unsig;
    logic [1:0]  shop;
    logic [4:0]  amt;
    logic [1:0]  mdop;
    logic [31:0] a, b, imm;
    logic        wr, wov;
    logic [4:0]  rd;
  } op_t;

  typedef struct packed {
    logic [31:0] wb;
    logic        wr;
    logic [4:0]  rd;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] last_wb = '0;
  logic [4:0]  rd_ctr = 5'd1;
  localparam int MD_STALLS = W + 1;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h want 0x%08h", tag, act, exp);
    end
  endtask

  function automatic op_t alu(input logic [2:0] aop, input logic [31:0] a, input logic [31:0] b,
                              input logic unsig, input logic wov);
    op_t o = '0;
    o.aluop = aop; o.a = a; o.b = b; o.unsig = unsig; o.wov = wov; o.wr = 1'b1;
    return o;
  endfunction

  function automatic op_t sh(input logic [1:0] shop, input logic [31:0] b, input logic [4:0] amt);
    op_t o = '0;
    o.sel_sh = 1'b1; o.shop = shop; o.b = b; o.amt = amt; o.wr = 1'b1; o.a = 32'hDEAD_BEEF;
    return o;
  endfunction

  function automatic op_t md(input logic [1:0] mdop, input logic [31:0] a, input logic [31:0] b,
                             input logic unsig);
    op_t o = '0;
    o.mdop = mdop; o.a = a; o.b = b; o.unsig = unsig; o.wr = 1'b1;
    return o;
  endfunction

  function automatic logic [31:0] md_model(input logic [1:0] mdop, input logic unsig,
                                           input logic [31:0] a, input logic [31:0] b);
    if (mdop == 2'b01) return a * b;
    if (b == 32'd0)    return (mdop == 2'b10) ? 32'hFFFF_FFFF : a;
    if (unsig)         return (mdop == 2'b10) ? a / b : a % b;
    return (mdop == 2'b10) ? 32'($signed(a) / $signed(b)) : 32'($signed(a) % $signed(b));
  endfunction

  task automatic apply(input op_t o);
    id_ex_selalushift = o.sel_sh; id_ex_selimregb = o.sel_imm; id_ex_aluop = o.aluop;
    id_ex_unsig = o.unsig; id_ex_shiftop = o.shop; id_ex_shiftamt = o.amt; id_ex_mdop = o.mdop;
    id_ex_rega = o.a; id_ex_regb = o.b; id_ex_imedext = o.imm; id_ex_writereg = o.wr;
    id_ex_writeov = o.wov; id_ex_regdest = o.rd;
  endtask

  // Drive one instruction, hold it while decode is stalled, then compare the
  // registered result and the stall count; mem_stall is raised for ms_len
  // cycles starting at cycle ms_at of the instruction.
  task automatic issue(input string tag, input op_t o, input logic [31:0] exp_wb,
                       input logic exp_wr, input int exp_stalls, input int ms_at, input int ms_len);
    int   stalls;
    logic accepted;
    exp_t e;
    @(negedge clock);
    o.rd = rd_ctr;
    rd_ctr = rd_ctr + 5'd1;
    apply(o);
    id_ex_valid = 1'b1;
    sb.push_back('{wb: exp_wb, wr: exp_wr, rd: o.rd});
    stalls = 0;
    accepted = 1'b0;
    for (int c = 0; c < 200; c++) begin
      mem_stall = (ms_len > 0) && (c >= ms_at) && (c < ms_at + ms_len);
      #1;
      if (mem_stall) begin
        check({tag, "_hold_wb"}, id_mem_wbvalue, last_wb);
        check({tag, "_hold_valid"}, {31'd0, ex_mem_valid}, 32'd0);
      end
      if (!id_if_stall) begin
        accepted = 1'b1;
        break;
      end
      stalls++;
      @(negedge clock);
    end
    check({tag, "_accepted"}, {31'd0, accepted}, 32'd1);
    check({tag, "_stalls"}, stalls, exp_stalls);
    @(negedge clock);
    id_ex_valid = 1'b0;
    mem_stall = 1'b0;
    #1;
    check({tag, "_valid"}, {31'd0, ex_mem_valid}, 32'd1);
    check({tag, "_sb_depth"}, sb.size(), 32'd1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check({tag, "_wb"}, id_mem_wbvalue, e.wb);
      check({tag, "_wr"}, {31'd0, id_mem_writereg}, {31'd0, e.wr});
      check({tag, "_rd"}, {27'd0, id_mem_regdest}, {27'd0, e.rd});
      last_wb = e.wb;
    end
    @(negedge clock);
    #1;
    check({tag, "_bubble"}, {30'd0, ex_mem_valid, id_mem_writereg}, 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    op_t         o;
    logic [1:0]  mop;
    logic        us;
    logic [31:0] ra, rb;

    reset = 1'b1; mem_stall = 1'b0; id_ex_valid = 1'b0;
    id_ex_readmem = 1'b0; id_ex_writemem = 1'b0; id_ex_selwsource = 1'b0;
    apply('0);
    repeat (3) @(negedge clock);
    #1;
    check("rst_valid", {31'd0, ex_mem_valid}, 32'd0);
    check("rst_wb", id_mem_wbvalue, 32'd0);
    check("rst_wr", {31'd0, id_mem_writereg}, 32'd0);
    check("rst_rd", {27'd0, id_mem_regdest}, 32'd0);
    check("rst_stall", {31'd0, id_if_stall}, 32'd0);
    reset = 1'b0;

    issue("add_ov",    alu(3'b000, 32'h7FFF_FFFF, 32'd1, 1'b0, 1'b0), 32'h8000_0000, 1'b0, 0, -1, 0);
    issue("add_ov_wo", alu(3'b000, 32'h7FFF_FFFF, 32'd1, 1'b0, 1'b1), 32'h8000_0000, 1'b1, 0, -1, 0);
    issue("add_u",     alu(3'b000, 32'h7FFF_FFFF, 32'd1, 1'b1, 1'b0), 32'h8000_0000, 1'b1, 0, -1, 0);
    issue("sub_ov",    alu(3'b001, 32'h8000_0000, 32'd1, 1'b0, 1'b0), 32'h7FFF_FFFF, 1'b0, 0, -1, 0);
    issue("slt_s",     alu(3'b110, 32'hFFFF_FFFF, 32'd1, 1'b0, 1'b0), 32'd1, 1'b1, 0, -1, 0);
    issue("slt_u",     alu(3'b110, 32'hFFFF_FFFF, 32'd1, 1'b1, 1'b0), 32'd0, 1'b1, 0, -1, 0);
    issue("nor",       alu(3'b101, 32'h0F0F_0F0F, 32'h00FF_00FF, 1'b0, 1'b0), 32'hF000_F000, 1'b1, 0, -1, 0);
    o = alu(3'b001, 32'd10, 32'h55, 1'b0, 1'b0);
    o.sel_imm = 1'b1; o.imm = 32'd3;
    issue("sub_imm", o, 32'd7, 1'b1, 0, -1, 0);
    issue("sra",  sh(2'b10, 32'h8000_0000, 5'd4), 32'hF800_0000, 1'b1, 0, -1, 0);
    issue("ror",  sh(2'b11, 32'h0000_0001, 5'd1), 32'h8000_0000, 1'b1, 0, -1, 0);
    issue("ror0", sh(2'b11, 32'h1234_5678, 5'd0), 32'h1234_5678, 1'b1, 0, -1, 0);
    issue("sll",  sh(2'b00, 32'h0000_00F1, 5'd8), 32'h0000_F100, 1'b1, 0, -1, 0);
    issue("srl",  sh(2'b01, 32'h8000_0000, 5'd31), 32'd1, 1'b1, 0, -1, 0);

    issue("mul_s",  md(2'b01, 32'hFFFF_FFFD, 32'd7, 1'b0), 32'hFFFF_FFEB, 1'b1, MD_STALLS, -1, 0);
    issue("div_s",  md(2'b10, 32'hFFFF_FFF9, 32'd2, 1'b0), 32'hFFFF_FFFD, 1'b1, MD_STALLS, -1, 0);
    issue("rem_s",  md(2'b11, 32'hFFFF_FFF9, 32'd2, 1'b0), 32'hFFFF_FFFF, 1'b1, MD_STALLS, -1, 0);
    issue("div_z",  md(2'b10, 32'd5, 32'd0, 1'b0), 32'hFFFF_FFFF, 1'b1, MD_STALLS, -1, 0);
    issue("rem_z",  md(2'b11, 32'd5, 32'd0, 1'b0), 32'd5, 1'b1, MD_STALLS, -1, 0);
    issue("div_u",  md(2'b10, 32'hFFFF_FFF9, 32'd2, 1'b1), 32'h7FFF_FFFC, 1'b1, MD_STALLS, -1, 0);
    issue("mul_ms", md(2'b01, 32'd6, 32'd7, 1'b0), 32'd42, 1'b1, MD_STALLS + 4, MD_STALLS, 4);

    // Abort a divide with reset in its tenth cycle.
    @(negedge clock);
    apply(md(2'b10, 32'hFFFF_FF9C, 32'd3, 1'b0));
    id_ex_valid = 1'b1;
    repeat (10) @(negedge clock);
    reset = 1'b1;
    id_ex_valid = 1'b0;
    @(negedge clock);
    #1;
    check("abort_valid", {31'd0, ex_mem_valid}, 32'd0);
    check("abort_wb", id_mem_wbvalue, 32'd0);
    check("abort_ctl", {28'd0, id_mem_readmem, id_mem_writemem, id_mem_selwsource, id_mem_writereg}, 32'd0);
    check("abort_regb", id_mem_regb, 32'd0);
    check("abort_rd", {27'd0, id_mem_regdest}, 32'd0);
    check("abort_stall", {31'd0, id_if_stall}, 32'd0);
    reset = 1'b0;
    last_wb = '0;
    issue("add_after", alu(3'b000, 32'd2, 32'd3, 1'b0, 1'b0), 32'd5, 1'b1, 0, -1, 0);

    for (int i = 0; i < 16; i++) begin
      mop = 2'($urandom_range(1, 3));
      us  = 1'($urandom_range(0, 1));
      ra  = $urandom;
      rb  = ($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(1, 20));
      if ($urandom_range(0, 1) == 1) rb = -rb;
      if (rb == 32'd0) rb = 32'd1;
      if (!us && ra == 32'h8000_0000 && rb == 32'hFFFF_FFFF) rb = 32'd2;
      issue("md_rand", md(mop, ra, rb, us), md_model(mop, us, ra, rb), 1'b1, MD_STALLS, -1, 0);
      ra = $urandom;
      rb = $urandom;
      issue("add_rand", alu(3'b000, ra, rb, 1'b1, 1'b0), ra + rb, 1'b1, 0, -1, 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
